// File: rtl/i2c_slave_rx.sv
// I2C slave receive front end: pin synchronisers, START/STOP detection,
// address match, data byte capture and ACK/NACK drive.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       byte_pending,
    input  logic       rx_ack,
    output logic       rw_bit,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    // Synchronisers reset to the idle-bus level so leaving reset never
    // looks like a bus edge.
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;
    logic start_cond;
    logic stop_cond;

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign sda_rise   = sda_s & ~sda_d;
    assign sda_fall   = ~sda_s & sda_d;
    assign start_cond = sda_fall & scl_s;
    assign stop_cond  = sda_rise & scl_s;

    state_t     state;
    state_t     state_n;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_n;
    logic [7:0] shift;
    logic [7:0] shift_n;
    logic [7:0] new_byte;
    logic       ack_phase;
    logic       ack_phase_n;
    logic       ack_en;
    logic       ack_en_n;
    logic       drive_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n;
    logic       pending_n;
    logic       rw_n;
    logic       addressed_n;
    logic       start_n;
    logic       stop_n;
    logic       overrun_n;

    assign new_byte = {shift[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shift         <= 8'h00;
            ack_phase     <= 1'b0;
            ack_en        <= 1'b0;
            sda_drive_low <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            byte_pending  <= 1'b0;
            rw_bit        <= 1'b0;
            addressed     <= 1'b0;
            start_det     <= 1'b0;
            stop_det      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shift         <= shift_n;
            ack_phase     <= ack_phase_n;
            ack_en        <= ack_en_n;
            sda_drive_low <= drive_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            byte_pending  <= pending_n;
            rw_bit        <= rw_n;
            addressed     <= addressed_n;
            start_det     <= start_n;
            stop_det      <= stop_n;
            overrun       <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        ack_phase_n = ack_phase;
        ack_en_n    = ack_en;
        drive_n     = sda_drive_low;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        // A consumer ack is applied before any byte completing this cycle.
        pending_n   = byte_pending & ~rx_ack;
        rw_n        = rw_bit;
        addressed_n = addressed;
        start_n     = 1'b0;
        stop_n      = 1'b0;
        overrun_n   = overrun;

        if (stop_cond) begin
            state_n     = IDLE;
            addressed_n = 1'b0;
            drive_n     = 1'b0;
            stop_n      = 1'b1;
        end else if (start_cond) begin
            state_n     = ADDR;
            bit_cnt_n   = 3'd0;
            ack_phase_n = 1'b0;
            addressed_n = 1'b0;
            drive_n     = 1'b0;
            start_n     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    drive_n = 1'b0;
                end
                ADDR, DATA: begin
                    drive_n = 1'b0;
                    if (scl_rise) begin
                        shift_n   = new_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n   = 3'd0;
                            ack_phase_n = 1'b0;
                            if (state == ADDR) begin
                                if (new_byte[7:1] == SLAVE_ADDR) begin
                                    rw_n        = new_byte[0];
                                    addressed_n = 1'b1;
                                    ack_en_n    = 1'b1;
                                    state_n     = ADDR_ACK;
                                end else begin
                                    state_n = IGNORE;
                                end
                            end else begin
                                state_n = DATA_ACK;
                                if (!pending_n) begin
                                    rx_data_n  = new_byte;
                                    rx_valid_n = 1'b1;
                                    pending_n  = 1'b1;
                                    ack_en_n   = 1'b1;
                                end else begin
                                    overrun_n = 1'b1;
                                    ack_en_n  = 1'b0;
                                end
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_n = 1'b1;
                            drive_n     = ack_en;
                        end else begin
                            ack_phase_n = 1'b0;
                            drive_n     = 1'b0;
                            // Read transfers are handled elsewhere.
                            if (state == ADDR_ACK && rw_bit)
                                state_n = IGNORE;
                            else
                                state_n = DATA;
                        end
                    end
                end
                IGNORE: begin
                    drive_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    drive_n = 1'b0;
                end
            endcase
        end
    end

endmodule
